board_sprite_addr_gen: RTL and testbench
========================================

// Module: board_sprite_addr_gen
// PURPOSE
//  Pixel-to-sprite address stage between the VGA scan counter and the sprite ROM.
//  Per visible pixel: finds the board square, reads the piece code from board RAM,
//  then emits the sprite ROM word address using the package piece codes and ROM bases.
//  The downstream colour mapper consumes rom_addr / sprite_en / dark_sq.
// PARAMETERS
//  SQUARE_DIM    60     square edge in pixels; sprite is SQUARE_DIM x SQUARE_DIM words
//  BOARD_X0      80     leftmost board pixel column (board spans X0..X0+8*DIM-1)
//  BOARD_Y0      0      top board pixel row
//  SPRITE_WORDS  3600   words per sprite (= SQUARE_DIM*SQUARE_DIM)
//  ADDR_W        17     rom_addr width (covers 0..79199)
// PORTS
//  Clk         in   1       system clock, all state on rising edge
//  Reset_n     in   1       synchronous reset, active low
//  pix_valid   in   1       DrawX/DrawY are a visible pixel this cycle
//  DrawX       in   10      pixel column
//  DrawY       in   10      pixel row
//  board_addr  out  6       board RAM read address, row*8+col
//  board_data  in   4       piece code from board RAM; 1-cycle synchronous read
//  out_valid   out  1       outputs below correspond to a pixel sampled 3 cycles earlier
//  in_board    out  1       that pixel lies inside the 8x8 board
//  sprite_en   out  1       square holds a valid piece; rom_addr is meaningful
//  dark_sq     out  1       (row+col) odd, i.e. a dark square
//  rom_addr    out  ADDR_W  sprite ROM word address
// BEHAVIOUR
//  - Reset (Reset_n=0 at an edge): all outputs and pipeline valids go to 0.
//    board_addr also goes to 0. Release mid-frame: out_valid stays 0 until the
//    first pixel sampled after release reaches stage 3.
//  - Stage 1 (edge 1):
//    - dx = DrawX-BOARD_X0, dy = DrawY-BOARD_Y0; inb = 0<=dx<8*DIM and 0<=dy<8*DIM.
//    - col/row (3b) come from a compare chain against k*DIM, k=1..7. No divider.
//    - xo = dx-col*DIM and yo = dy-row*DIM, each 6b, 0..DIM-1.
//    - board_addr <= {row,col} is registered. Outside the board it holds its last value.
//  - Stage 2 (edge 2): RAM returns board_data. xo, yo, inb, dark, valid are delayed to match.
//  - Stage 3 (edge 3), outputs registered:
//    - t = board_data[2:0], blk = board_data[3].
//    - Piece is valid if t in 1..6 and inb.
//    - idx = (t-1)*2 + (blk ? 0 : 1); base = idx*SPRITE_WORDS.
//    - rom_addr = base + yo*DIM + xo.
//    - Invalid piece (t=0 EMPTY, t=7, or !inb): sprite_en=0, rom_addr=0.
//  - Latency is exactly 3 cycles, fully pipelined, one pixel per clock, no stalls.
//  - out_valid = pix_valid delayed by 3. When 0, in_board/sprite_en/dark_sq/rom_addr are 0.
//  - DrawX < BOARD_X0 is handled by the sign of dx (11b signed): gives in_board=0.
//    No wrap to the right edge.
//  - Boundary pixels:
//    - DrawX = X0+8*DIM-1 -> col 7, xo = DIM-1.
//    - DrawX = X0+8*DIM   -> in_board 0.
//  - Max rom_addr = 11*3600+3599 = 43199. The digit sprites above that are never addressed here.
// CONFIGURATION
//  FLIP_BOARD_EN defined: view from black's side.
//    - Stage 1 uses row'=7-row, col'=7-col for board_addr only.
//    - xo/yo, and therefore sprite orientation, are unchanged.
//    - dark_sq is still (row+col) odd on the screen position.
//  FLIP_BOARD_EN undefined: board_addr = row*8+col; row 0 is the top screen row (rank 8).
// TESTING
//  1. Reset held 4 clks while pixels stream -> all outputs 0. After release, out_valid rises on the 3rd edge.
//  2. (80,0), board[0]=4'b1100 ROOK_BLACK -> 3 clks later: board_addr 0, rom_addr 21600, sprite_en 1, dark_sq 0.
//  3. (139,59), board[0]=4'b0110 KING_WHITE -> rom_addr 39600+59*60+59 = 43199, sprite_en 1.
//  4. (140,60), board[9]=4'b0001 PAWN_WHITE -> board_addr 9, rom_addr 3600, dark_sq 0.
//     Board code 0 or 4'b0111 -> sprite_en 0, rom_addr 0.
//  5. (79,10) and (560,10) -> in_board 0, sprite_en 0.
//     (559,479) -> board_addr 63, rom_addr base+3599.
//  6. FLIP_BOARD_EN build: (80,0) -> board_addr 63. (559,479) -> board_addr 0. rom_addr offsets unchanged.

Source files
------------

// File: rtl/board_sprite_addr_gen.sv
// Pixel-to-sprite address stage: scan position -> board square -> piece code -> sprite ROM word.
// Three-stage pipeline, one pixel per clock. Define FLIP_BOARD_EN to view the board from black's side.
module board_sprite_addr_gen #(
  parameter int SQUARE_DIM   = 60,
  parameter int BOARD_X0     = 80,
  parameter int BOARD_Y0     = 0,
  parameter int SPRITE_WORDS = 3600,
  parameter int ADDR_W       = 17
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              pix_valid,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [5:0]        board_addr,
  input  logic [3:0]        board_data,
  output logic              out_valid,
  output logic              in_board,
  output logic              sprite_en,
  output logic              dark_sq,
  output logic [ADDR_W-1:0] rom_addr
);

  localparam int BOARD_PIX = 8 * SQUARE_DIM;

  // Stage 1 combinational: board-relative offsets, square index, offset inside the square.
  logic signed [10:0] dx_c, dy_c;
  logic [2:0]         col_c, row_c;
  logic [5:0]         xo_c, yo_c;
  logic               inb_c;
  logic [5:0]         board_addr_d;

  assign dx_c = $signed({1'b0, DrawX}) - $signed(11'(BOARD_X0));
  assign dy_c = $signed({1'b0, DrawY}) - $signed(11'(BOARD_Y0));

  assign inb_c = !dx_c[10] && (dx_c < $signed(11'(BOARD_PIX))) &&
                 !dy_c[10] && (dy_c < $signed(11'(BOARD_PIX)));

  // Compare chain against k*DIM replaces a divider; the last threshold passed wins.
  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    col_c = '0;
    row_c = '0;
    xo_c  = dx_c[5:0];
    yo_c  = dy_c[5:0];
    for (int k = 1; k < 8; k++) begin
      if (dx_c >= $signed(11'(k * SQUARE_DIM))) begin
        col_c = 3'(k);
        xo_c  = 6'(dx_c - $signed(11'(k * SQUARE_DIM)));
      end
      if (dy_c >= $signed(11'(k * SQUARE_DIM))) begin
        row_c = 3'(k);
        yo_c  = 6'(dy_c - $signed(11'(k * SQUARE_DIM)));
      end
    end
  end

  // Off-board or blank pixels leave the RAM address where it was.
  always_comb begin
    board_addr_d = board_addr;
    if (pix_valid && inb_c) begin
`ifdef FLIP_BOARD_EN
      board_addr_d = {~row_c, ~col_c};
`else
      board_addr_d = {row_c, col_c};
`endif
    end
  end

  // Stage 1 / stage 2 pipeline registers.
  logic       s1_valid_q, s1_inb_q, s1_dark_q;
  logic [5:0] s1_xo_q, s1_yo_q;
  logic       s2_valid_q, s2_inb_q, s2_dark_q;
  logic [5:0] s2_xo_q, s2_yo_q;

  // NOTE: sequential state uses non-blocking assignments so all stages advance from the same sampled values.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      board_addr <= '0;
      s1_valid_q <= 1'b0;
      s1_inb_q   <= 1'b0;
      s1_dark_q  <= 1'b0;
      s1_xo_q    <= '0;
      s1_yo_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_inb_q   <= 1'b0;
      s2_dark_q  <= 1'b0;
      s2_xo_q    <= '0;
      s2_yo_q    <= '0;
    end else begin
      board_addr <= board_addr_d;
      s1_valid_q <= pix_valid;
      s1_inb_q   <= inb_c;
      s1_dark_q  <= row_c[0] ^ col_c[0];
      s1_xo_q    <= xo_c;
      s1_yo_q    <= yo_c;
      s2_valid_q <= s1_valid_q;
      s2_inb_q   <= s1_inb_q;
      s2_dark_q  <= s1_dark_q;
      s2_xo_q    <= s1_xo_q;
      s2_yo_q    <= s1_yo_q;
    end
  end

  // Stage 3 combinational: piece decode and sprite word address.
  logic [2:0]        piece_t;
  logic              piece_blk, piece_ok;
  logic [3:0]        sprite_idx;
  logic [ADDR_W-1:0] rom_addr_d;
  logic              out_valid_d, in_board_d, sprite_en_d, dark_sq_d;

  assign piece_t    = board_data[2:0];
  assign piece_blk  = board_data[3];
  assign piece_ok   = s2_valid_q && s2_inb_q && (piece_t != 3'd0) && (piece_t != 3'd7);
  // Black sprite of each type comes first, white second.
  assign sprite_idx = {piece_t - 3'd1, ~piece_blk};

  always_comb begin
    out_valid_d = s2_valid_q;
    in_board_d  = s2_valid_q && s2_inb_q;
    dark_sq_d   = s2_valid_q && s2_inb_q && s2_dark_q;
    sprite_en_d = piece_ok;
    rom_addr_d  = '0;
    if (piece_ok) begin
      rom_addr_d = ADDR_W'(sprite_idx) * ADDR_W'(SPRITE_WORDS)
                 + ADDR_W'(s2_yo_q) * ADDR_W'(SQUARE_DIM)
                 + ADDR_W'(s2_xo_q);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      out_valid <= 1'b0;
      in_board  <= 1'b0;
      sprite_en <= 1'b0;
      dark_sq   <= 1'b0;
      rom_addr  <= '0;
    end else begin
      out_valid <= out_valid_d;
      in_board  <= in_board_d;
      sprite_en <= sprite_en_d;
      dark_sq   <= dark_sq_d;
      rom_addr  <= rom_addr_d;
    end
  end

endmodule

// File: tb/tb_board_sprite_addr_gen.sv
// Bench for board_sprite_addr_gen: directed vector table, randomized stream against a
// division-based reference model, and reset-during-stream sequences.
module tb_board_sprite_addr_gen;

  localparam int DIM = 60;
  localparam int X0  = 80;
  localparam int Y0  = 0;
  localparam int SW  = 3600;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        pix_valid = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic [5:0]  board_addr;
  logic [3:0]  board_data;
  logic        out_valid, in_board, sprite_en, dark_sq;
  logic [16:0] rom_addr;

  board_sprite_addr_gen dut (
    .Clk(Clk), .Reset_n(Reset_n), .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY),
    .board_addr(board_addr), .board_data(board_data), .out_valid(out_valid),
    .in_board(in_board), .sprite_en(sprite_en), .dark_sq(dark_sq), .rom_addr(rom_addr)
  );

  always #5 Clk = ~Clk;

  // Board RAM with one-cycle synchronous read.
  logic [3:0] mem [64];
  always @(posedge Clk) board_data <= mem[board_addr];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int fa(input int a);
`ifdef FLIP_BOARD_EN
    return 63 - a;
`else
    return a;
`endif
  endfunction

  typedef struct {
    bit v;
    bit inb;
    bit spr;
    bit dark;
    int rom;
    int ba;
  } exp_t;

  // Reference: plain division/modulo on screen coordinates.
  function automatic exp_t model(input bit v, input int x, input int y);
    exp_t e = '{default: 0};
    int dx, dy, row, col, code, t;
    dx = x - X0;
    dy = y - Y0;
    e.v = v;
    if (dx >= 0 && dx < 8 * DIM && dy >= 0 && dy < 8 * DIM) begin
      row  = dy / DIM;
      col  = dx / DIM;
      e.ba = fa(row * 8 + col);
      if (v) begin
        e.inb  = 1'b1;
        e.dark = ((row + col) % 2) == 1;
        code   = int'(mem[e.ba]);
        t      = code % 8;
        if (t >= 1 && t <= 6) begin
          e.spr = 1'b1;
          e.rom = ((t - 1) * 2 + (code >= 8 ? 0 : 1)) * SW + (dy % DIM) * DIM + (dx % DIM);
        end
      end
    end
    return e;
  endfunction

  exp_t pipe[$];

  // Drive one pixel, advance one clock, check against the model.
  task automatic step(input bit v, input int x, input int y);
    exp_t e, o;
    bit   rst;
    pix_valid = v;
    DrawX     = 10'(x);
    DrawY     = 10'(y);
    rst       = !Reset_n;
    e         = model(v, x, y);
    pipe.push_back(e);
    @(posedge Clk);
    @(negedge Clk);
    if (rst) begin
      pipe.delete();
      check("rst out_valid", 32'(out_valid), 0);
      check("rst in_board", 32'(in_board), 0);
      check("rst sprite_en", 32'(sprite_en), 0);
      check("rst dark_sq", 32'(dark_sq), 0);
      check("rst rom_addr", 32'(rom_addr), 0);
      check("rst board_addr", 32'(board_addr), 0);
    end else begin
      if (e.inb) check("board_addr", 32'(board_addr), 32'(e.ba));
      if (pipe.size() == 3) begin
        o = pipe.pop_front();
        check("out_valid", 32'(out_valid), 32'(o.v));
        check("in_board", 32'(in_board), 32'(o.inb));
        check("sprite_en", 32'(sprite_en), 32'(o.spr));
        check("rom_addr", 32'(rom_addr), 32'(o.rom));
        if (o.inb || !o.v) check("dark_sq", 32'(dark_sq), 32'(o.dark));
      end else begin
        check("fill out_valid", 32'(out_valid), 0);
      end
    end
  endtask

  task automatic rand_step();
    int bx[7] = '{79, 80, 139, 140, 559, 560, 619};
    int by[5] = '{0, 59, 60, 479, 480};
    int x, y;
    x = ($urandom_range(0, 3) == 0) ? bx[$urandom_range(0, 6)] : int'($urandom_range(0, 639));
    y = ($urandom_range(0, 3) == 0) ? by[$urandom_range(0, 4)] : int'($urandom_range(0, 524));
    step($urandom_range(0, 4) != 0, x, y);
  endtask

  typedef struct {
    bit v;
    int x;
    int y;
    int code;
    int ld;   // RAM word to load with code, -1 = none
    int ba;   // expected board_addr after stage 1, -1 = unchecked
    bit inb;
    bit spr;
    bit dark;
    int rom;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 4'h0;

    vecs[0]  = '{1, 80,  0,   4'hC, fa(0),  fa(0),  1, 1, 0, 21600};
    vecs[1]  = '{1, 139, 59,  4'h6, fa(0),  fa(0),  1, 1, 0, 43199};
    vecs[2]  = '{1, 140, 60,  4'h1, fa(9),  fa(9),  1, 1, 0, 3600};
    vecs[3]  = '{1, 140, 60,  4'h0, fa(9),  fa(9),  1, 0, 0, 0};
    vecs[4]  = '{1, 140, 60,  4'h7, fa(9),  fa(9),  1, 0, 0, 0};
    vecs[5]  = '{1, 79,  10,  4'h0, -1,     fa(9),  0, 0, 0, 0};
    vecs[6]  = '{1, 560, 10,  4'h0, -1,     fa(9),  0, 0, 0, 0};
    vecs[7]  = '{1, 559, 479, 4'h9, fa(63), fa(63), 1, 1, 0, 3599};
    vecs[8]  = '{1, 100, 480, 4'h0, -1,     fa(63), 0, 0, 0, 0};
    vecs[9]  = '{1, 260, 130, 4'hA, fa(19), fa(19), 1, 1, 1, 7800};
    vecs[10] = '{1, 559, 0,   4'hD, fa(7),  fa(7),  1, 1, 1, 28859};
    vecs[11] = '{0, 80,  0,   4'hC, fa(0),  -1,     0, 0, 0, 0};

    @(negedge Clk);

    // Reset held 4 clocks while pixels stream; out_valid rises on the 3rd edge after release.
    Reset_n = 1'b0;
    for (int i = 0; i < 4; i++) rand_step();
    Reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 80 + i, 5);
    check("release out_valid", 32'(out_valid), 1);
    step(1'b0, 0, 0);
    step(1'b0, 0, 0);
    step(1'b0, 0, 0);

    // Directed vectors, each flushed before the next.
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].ld >= 0) mem[vecs[i].ld] = 4'(vecs[i].code);
      step(vecs[i].v, vecs[i].x, vecs[i].y);
      if (vecs[i].ba >= 0) check($sformatf("vec%0d board_addr", i), 32'(board_addr), 32'(vecs[i].ba));
      step(1'b0, 0, 0);
      step(1'b0, 0, 0);
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].v));
      check($sformatf("vec%0d in_board", i), 32'(in_board), 32'(vecs[i].inb));
      check($sformatf("vec%0d sprite_en", i), 32'(sprite_en), 32'(vecs[i].spr));
      check($sformatf("vec%0d dark_sq", i), 32'(dark_sq), 32'(vecs[i].dark));
      check($sformatf("vec%0d rom_addr", i), 32'(rom_addr), 32'(vecs[i].rom));
    end

    // Randomized stream over a random board.
    for (int i = 0; i < 64; i++) mem[i] = 4'($urandom_range(0, 15));
    for (int i = 0; i < 3000; i++) rand_step();

    // Reset in the middle of a stream, then resume.
    Reset_n = 1'b0;
    for (int i = 0; i < 4; i++) rand_step();
    Reset_n = 1'b1;
    for (int i = 0; i < 300; i++) rand_step();
    for (int i = 0; i < 3; i++) step(1'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
